// File: rtl/gb_frame_sequencer.sv
// Game Boy APU frame sequencer: turns a 512 Hz tick into the 256 Hz length,
// 128 Hz sweep and 64 Hz envelope clock pulses over an 8-step cycle.
module gb_frame_sequencer #(
    parameter int DIV_CYCLES  = 8192,
    parameter bit USE_EXT_DIV = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_enable,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_envelope,
    output logic [2:0] step,
    output logic       length_next_skip
);

    localparam int            PW         = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_CYCLES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          div_prev_q;
    logic [2:0]    step_q, step_d;
    logic          len_q, len_d;
    logic          sweep_q, sweep_d;
    logic          env_q, env_d;
    logic          tick;

    // Returns {length, sweep, envelope} for the step being executed.
    function automatic logic [2:0] decode_step(input logic [2:0] s);
        logic len_f, sweep_f, env_f;
        len_f   = ~s[0];
        sweep_f = (s[1:0] == 2'b10);
        env_f   = (s == 3'd7);
        return {len_f, sweep_f, env_f};
    endfunction

    always_comb begin
        tick = 1'b0;
        if (USE_EXT_DIV) begin
            tick = apu_enable & div_prev_q & ~div_bit;
        end else begin
            tick = apu_enable & (presc_q == PRESC_LAST);
        end
    end

    always_comb begin
        presc_d = '0;
        if (!USE_EXT_DIV && apu_enable && (presc_q != PRESC_LAST)) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        step_d  = step_q;
        len_d   = 1'b0;
        sweep_d = 1'b0;
        env_d   = 1'b0;
        if (!apu_enable) begin
            step_d = 3'd0;
        end else if (tick) begin
            step_d                 = step_q + 3'd1;
            {len_d, sweep_d, env_d} = decode_step(step_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            div_prev_q <= 1'b0;
            step_q     <= 3'd0;
            len_q      <= 1'b0;
            sweep_q    <= 1'b0;
            env_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            div_prev_q <= div_bit;
            step_q     <= step_d;
            len_q      <= len_d;
            sweep_q    <= sweep_d;
            env_q      <= env_d;
        end
    end

    assign clk_length_ctr   = len_q;
    assign clk_sweep        = sweep_q;
    assign clk_envelope     = env_q;
    assign step             = step_q;
    assign length_next_skip = step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Bench for gb_frame_sequencer: one internal-prescaler and one external-DIV
// instance checked cycle by cycle against a tick-counting reference model.
module tb_gb_frame_sequencer;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic apu_enable;
    logic div_bit;

    logic       i_len, i_sw, i_env, i_lns;
    logic [2:0] i_step;
    logic       e_len, e_sw, e_env, e_lns;
    logic [2:0] e_step;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = internal instance, 1 = external instance.
    int m_step[2];
    int m_tstep[2];
    bit m_len[2], m_sw[2], m_env[2];
    int m_cnt;
    bit m_prev;

    always #5 clk = ~clk;

    gb_frame_sequencer #(.DIV_CYCLES(DIV), .USE_EXT_DIV(1'b0)) u_int (
        .clk(clk), .reset(reset), .apu_enable(apu_enable), .div_bit(div_bit),
        .clk_length_ctr(i_len), .clk_sweep(i_sw), .clk_envelope(i_env),
        .step(i_step), .length_next_skip(i_lns)
    );

    gb_frame_sequencer #(.DIV_CYCLES(DIV), .USE_EXT_DIV(1'b1)) u_ext (
        .clk(clk), .reset(reset), .apu_enable(apu_enable), .div_bit(div_bit),
        .clk_length_ctr(e_len), .clk_sweep(e_sw), .clk_envelope(e_env),
        .step(e_step), .length_next_skip(e_lns)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 0; m_tstep[i] = 0;
            m_len[i] = 0; m_sw[i] = 0; m_env[i] = 0;
        end
        m_cnt  = 0;
        m_prev = 0;
    endtask

    // Evaluate one clock edge with the inputs currently applied.
    task automatic model_edge();
        bit t[2];
        t[0] = apu_enable && ((m_cnt % DIV) == DIV - 1);
        t[1] = apu_enable && m_prev && !div_bit;
        for (int i = 0; i < 2; i++) begin
            m_len[i] = t[i] && ((m_step[i] % 2) == 0);
            m_sw[i]  = t[i] && (m_step[i] == 2 || m_step[i] == 6);
            m_env[i] = t[i] && (m_step[i] == 7);
            if (t[i]) m_tstep[i] = m_step[i];
            if (!apu_enable) m_step[i] = 0;
            else if (t[i])   m_step[i] = (m_step[i] + 1) % 8;
        end
        m_cnt  = apu_enable ? m_cnt + 1 : 0;
        m_prev = div_bit;
    endtask

    task automatic compare_all();
        check("int_step", i_step, m_step[0]);
        check("int_len",  i_len,  m_len[0]);
        check("int_sweep", i_sw,  m_sw[0]);
        check("int_env",  i_env,  m_env[0]);
        check("int_skip", i_lns,  m_step[0] % 2);
        check("ext_step", e_step, m_step[1]);
        check("ext_len",  e_len,  m_len[1]);
        check("ext_sweep", e_sw,  m_sw[1]);
        check("ext_env",  e_env,  m_env[1]);
        check("ext_skip", e_lns,  m_step[1] % 2);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int c_len, c_sw, c_env;
        bit found;

        // Reset held across edges with enable high and div_bit high.
        reset = 1'b1; apu_enable = 1'b1; div_bit = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();

        // Release with div_bit low: div_prev is 0, so no spurious tick.
        div_bit = 1'b0;
        #2 reset = 1'b0;

        // Continuous enable, div_bit toggled every 3 cycles, 40 cycles.
        c_len = 0; c_sw = 0; c_env = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 2) div_bit = ~div_bit;
            cycle();
            if (c < 32) begin
                c_len += int'(i_len); c_sw += int'(i_sw); c_env += int'(i_env);
            end
        end
        check("cnt32_len",   c_len, 4);
        check("cnt32_sweep", c_sw,  2);
        check("cnt32_env",   c_env, 1);

        // Drop enable while at step 5, toggle div_bit, then re-enable.
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (m_step[0] == 5) found = 1;
            else begin
                if (c % 3 == 0) div_bit = ~div_bit;
                cycle();
            end
        end
        check("reach_step5", int'(found), 1);
        apu_enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            div_bit = ~div_bit;
            cycle();
        end
        apu_enable = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) div_bit = ~div_bit;
            cycle();
        end

        // Asynchronous reset in the middle of the step-2 pulse.
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (c % 3 == 0) div_bit = ~div_bit;
            cycle();
            if (m_sw[0] && m_tstep[0] == 2) found = 1;
        end
        check("reach_step2_pulse", int'(found), 1);
        check("pre_rst_len",   i_len, 1);
        check("pre_rst_sweep", i_sw,  1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_len",   i_len,  0);
        check("async_rst_sweep", i_sw,   0);
        check("async_rst_step",  i_step, 0);
        compare_all();
        #2 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c % 3 == 1) div_bit = ~div_bit;
            cycle();
        end

        // Randomized enable and div_bit activity.
        for (int c = 0; c < 400; c++) begin
            apu_enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0) div_bit = ~div_bit;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
